// File: rtl/fpu_sp_align_shifter.sv
// fpu_sp_align_shifter
// Multi-cycle mantissa alignment for the single-precision add/sub path.
// Takes both operands and the exponent comparator results, then picks the
// larger-exponent operand. It right-shifts the smaller mantissa by the
// exponent difference, at most STEP bits per cycle, and keeps guard, round
// and sticky bits. The aligned pair goes out over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE, not in reset)
//   exp_a, exp_b          operand exponents
//   mant_a, mant_b        operand mantissas (hidden bit included)
//   difference            |exp_a - exp_b| from the comparator
//   sign                  1 when exp_a < exp_b
//   overflow              difference not representable; saturate the shift
//   out_valid / out_ready result handshake
//   exp_out               exponent of the larger operand
//   mant_large            unshifted mantissa of the larger operand
//   mant_small            aligned smaller mantissa, bits [2:0] = G, R, S
//   swapped               1 when operand b was taken as the larger operand
module fpu_sp_align_shifter #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8,
   parameter int STEP   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [EXP_W-1:0]    exp_a,
   input  logic [EXP_W-1:0]    exp_b,
   input  logic [MANT_W-1:0]   mant_a,
   input  logic [MANT_W-1:0]   mant_b,
   input  logic [EXP_W-1:0]    difference,
   input  logic                sign,
   input  logic                overflow,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [EXP_W-1:0]    exp_out,
   output logic [MANT_W-1:0]   mant_large,
   output logic [MANT_W+2:0]   mant_small,
   output logic                swapped
);

   localparam int WW = MANT_W + 3;
   localparam int RW = $clog2(WW + 1);
   localparam logic [RW-1:0] MAX_SH  = RW'(WW);
   localparam logic [RW-1:0] STEP_SH = RW'(STEP);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state;
   logic [RW-1:0] rem;
   logic [WW-1:0] w;
   logic [RW-1:0] rem_in;
   logic [RW-1:0] k;

   // Shifts beyond the full working width all give the same result, so the
   // remaining count is clamped to WW; overflow forces the clamp.
   function automatic logic [RW-1:0] clamp_shift(input logic [EXP_W-1:0] diff,
                                                 input logic ovf);
      if (ovf || (diff >= EXP_W'(WW)))
         return MAX_SH;
      else
         return diff[RW-1:0];
   endfunction

   // Right shift by k with every lost bit, and the old bit 0, folded into
   // the new bit 0 so the sticky bit survives across steps.
   function automatic logic [WW-1:0] shift_sticky(input logic [WW-1:0] v,
                                                  input logic [RW-1:0] sh);
      logic          lost;
      logic [WW-1:0] r;
      lost = 1'b0;
      for (int i = 0; i < WW; i++) begin
         if (i < int'(sh))
            lost = lost | v[i];
      end
      r    = v >> sh;
      r[0] = r[0] | lost;
      return r;
   endfunction

   assign rem_in = clamp_shift(difference, overflow);
   assign k      = (rem < STEP_SH) ? rem : STEP_SH;

   assign in_ready   = (state == IDLE) & ~rst;
   assign out_valid  = (state == DONE);
   assign mant_small = w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rem        <= '0;
         w          <= '0;
         exp_out    <= '0;
         mant_large <= '0;
         swapped    <= 1'b0;
      end else begin
         case (state)
            // capture: larger operand passes through, smaller one is loaded for shifting
            IDLE: begin
               if (in_valid) begin
                  if (sign) begin
                     exp_out    <= exp_b;
                     mant_large <= mant_b;
                     w          <= {mant_a, 3'b000};
                     swapped    <= 1'b1;
                  end else begin
                     exp_out    <= exp_a;
                     mant_large <= mant_a;
                     w          <= {mant_b, 3'b000};
                     swapped    <= 1'b0;
                  end
                  rem   <= rem_in;
                  state <= (rem_in != '0) ? SHIFT : DONE;
               end
            end
            // alignment: up to STEP bits per cycle
            SHIFT: begin
               w   <= shift_sticky(w, k);
               rem <= rem - k;
               if (rem == k)
                  state <= DONE;
            end
            // result held until the consumer takes it
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_sp_align_shifter.sv
module tb_fpu_sp_align_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  exp_a, exp_b, difference;
   logic [23:0] mant_a, mant_b;
   logic        sign, overflow;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  exp_out;
   logic [23:0] mant_large;
   logic [26:0] mant_small;
   logic        swapped;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]  e;
      logic [23:0] ml;
      logic [26:0] ms;
      logic        sw;
   } res_t;

   res_t sb[$];
   res_t mon_e;

   fpu_sp_align_shifter #(.MANT_W(24), .EXP_W(8), .STEP(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
      .difference(difference), .sign(sign), .overflow(overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .exp_out(exp_out), .mant_large(mant_large), .mant_small(mant_small),
      .swapped(swapped)
   );

   always #5 clk = ~clk;

   // Monitor: every accepted output is matched against the next expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output exp_out=%0h mant_small=%0h", exp_out, mant_small);
         end else begin
            mon_e = sb.pop_front();
            if ({exp_out, mant_large, mant_small, swapped} !== mon_e) begin
               errors++;
               $display("FAIL result actual e=%0h ml=%0h ms=%0h sw=%0b required e=%0h ml=%0h ms=%0h sw=%0b",
                        exp_out, mant_large, mant_small, swapped,
                        mon_e.e, mon_e.ml, mon_e.ms, mon_e.sw);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic [7:0] df, input logic sg, input logic ov);
      exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
      difference = df; sign = sg; overflow = ov;
   endtask

   // Issues one operand set (called just after a rising edge) and waits for
   // out_valid, checking the latency. Returns with out_valid seen.
   task automatic issue(input string nm,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic [7:0] df, input logic sg, input logic ov,
                        input res_t exp_r, input int lat);
      int cyc;
      chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
      sb.push_back(exp_r);
      drive(ea, eb, ma, mb, df, sg, ov);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // scramble inputs: only the captured values may matter
      drive(8'h5A, 8'hA5, 24'h3C3C3C, 24'hC3C3C3, 8'd7, ~sg, 1'b0);
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, "_latency"}, 64'(cyc), 64'(lat));
   endtask

   // Completes the handshake (out_ready high) and checks in_ready returns.
   task automatic finish_hs(input string nm);
      @(posedge clk); #1;
      chk({nm, "_ready_back"}, 64'({in_ready, out_valid}), 64'b10);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(8'd0, 8'd0, 24'd0, 24'd0, 8'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_outputs", {out_valid, exp_out, mant_large, mant_small, swapped}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Reset in the middle of a shift: nothing may come out.
      drive(8'd140, 8'd120, 24'hFFFFFF, 24'hFFFFFF, 8'd20, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midshift_busy", 64'({in_ready, out_valid}), 64'b00);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_outputs", {out_valid, exp_out, mant_large, mant_small, swapped}, 64'd0);
      rst = 1'b0;
      #1;
      chk("midrst_release", 64'(in_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_stale", 64'(out_valid), 64'd0);
      end

      // diff 3, a larger
      issue("d3", 8'd130, 8'd127, 24'h800000, 24'hC00001, 8'd3, 1'b0, 1'b0,
            '{e:8'd130, ml:24'h800000, ms:27'h0C00001, sw:1'b0}, 2);
      finish_hs("d3");
      // diff 2, b larger: G,R set, S clear
      issue("d2", 8'd127, 8'd129, 24'hFFFFFF, 24'h800000, 8'd2, 1'b1, 1'b0,
            '{e:8'd129, ml:24'h800000, ms:27'h1FFFFFE, sw:1'b1}, 2);
      finish_hs("d2");
      // diff 25: leading 1 lands in R, lost low bit sets S
      issue("d25", 8'd150, 8'd125, 24'hC00000, 24'h800001, 8'd25, 1'b0, 1'b0,
            '{e:8'd150, ml:24'hC00000, ms:27'h0000003, sw:1'b0}, 8);
      finish_hs("d25");
      // diff 26: leading 1 lands in S together with the lost bit
      issue("d26", 8'd100, 8'd126, 24'h800001, 24'h900000, 8'd26, 1'b1, 1'b0,
            '{e:8'd126, ml:24'h900000, ms:27'h0000001, sw:1'b1}, 8);
      finish_hs("d26");
      // diff 40 without overflow: clamped to full-width shift
      issue("d40", 8'd170, 8'd130, 24'hABCDEF, 24'h000001, 8'd40, 1'b0, 1'b0,
            '{e:8'd170, ml:24'hABCDEF, ms:27'h0000001, sw:1'b0}, 8);
      finish_hs("d40");
      // overflow, nonzero smaller mantissa
      issue("ovf_nz", 8'd129, 8'd0, 24'h812345, 24'h123456, 8'd0, 1'b0, 1'b1,
            '{e:8'd129, ml:24'h812345, ms:27'h0000001, sw:1'b0}, 8);
      finish_hs("ovf_nz");
      // overflow, zero smaller mantissa
      issue("ovf_z", 8'd129, 8'd0, 24'h812345, 24'h000000, 8'd0, 1'b0, 1'b1,
            '{e:8'd129, ml:24'h812345, ms:27'h0000000, sw:1'b0}, 8);
      finish_hs("ovf_z");

      // Backpressure on an equal-exponent operation
      out_ready = 1'b0;
      issue("eq", 8'd100, 8'd100, 24'hABCDEF, 24'hABCDEF, 8'd0, 1'b0, 1'b0,
            '{e:8'd100, ml:24'hABCDEF, ms:27'h55E6F78, sw:1'b0}, 1);
      for (int i = 0; i < 5; i++) begin
         drive(8'd200, 8'd10, 24'h111111, 24'h222222, 8'd190, 1'b0, 1'b0);
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("stall_ctrl", 64'({out_valid, in_ready}), 64'b10);
         chk("stall_data", {exp_out, mant_small, swapped}, {28'd0, 8'd100, 27'h55E6F78, 1'b0});
         chk("stall_large", 64'(mant_large), 64'hABCDEF);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      finish_hs("eq");

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
